// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bus: instruction memory port, IF/ID handshake to decode,
// and redirect/halt control coming back from later stages.
interface instr_fetch_unit_if #(
  parameter int PC_W  = 14,
  parameter int CNT_W = 32
);
  logic [PC_W-1:0]  pc;
  logic [31:0]      ir;
  logic [31:0]      if_instr;
  logic [PC_W-1:0]  if_pc;
  logic             if_valid;
  logic             id_ready;
  logic             redirect;
  logic [PC_W-1:0]  redirect_pc;
  logic             halt_req;
  logic             halted;
  logic [CNT_W-1:0] fetch_count;

  modport master (
    output pc, if_instr, if_pc, if_valid, halted, fetch_count,
    input  ir, id_ready, redirect, redirect_pc, halt_req
  );

  modport slave (
    input  pc, if_instr, if_pc, if_valid, halted, fetch_count,
    output ir, id_ready, redirect, redirect_pc, halt_req
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: drives pc into a combinational instruction memory and holds the
// returned word in the IF/ID register, handed to decode via valid/ready.
module instr_fetch_unit #(
  parameter int            PC_W     = 14,
  parameter int            CNT_W    = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic               clk,
  input logic               rst_n,
  instr_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_HALT
  } state_t;

  state_t           r_state;
  logic [PC_W-1:0]  r_pc;
  logic [31:0]      r_if_instr;
  logic [PC_W-1:0]  r_if_pc;
  logic             r_if_valid;
  logic             r_halted;
  logic [CNT_W-1:0] r_fetch_count;
  logic             w_xfer;

  assign w_xfer = r_if_valid & bus.id_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_BOOT;
      r_pc          <= RESET_PC;
      r_if_instr    <= '0;
      r_if_pc       <= '0;
      r_if_valid    <= 1'b0;
      r_halted      <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      // A transfer is counted even on an edge where a redirect flushes IF/ID.
      if (w_xfer)
        r_fetch_count <= r_fetch_count + CNT_W'(1);

      case (r_state)
        S_BOOT: begin
          r_state  <= bus.halt_req ? S_HALT : S_RUN;
          r_halted <= bus.halt_req;
        end

        S_RUN: begin
          if (bus.redirect) begin
            // Halt requested alongside a redirect is taken on the next edge.
            r_pc       <= bus.redirect_pc;
            r_if_valid <= 1'b0;
          end else if (bus.halt_req) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
            if (w_xfer)
              r_if_valid <= 1'b0;
          end else if (!r_if_valid || w_xfer) begin
            r_if_instr <= bus.ir;
            r_if_pc    <= r_pc;
            r_if_valid <= 1'b1;
            r_pc       <= r_pc + PC_W'(1);
          end
        end

        S_HALT: begin
          if (bus.redirect) begin
            r_pc       <= bus.redirect_pc;
            r_if_valid <= 1'b0;
          end else begin
            if (w_xfer)
              r_if_valid <= 1'b0;
            if (!bus.halt_req) begin
              r_state  <= S_RUN;
              r_halted <= 1'b0;
            end
          end
        end

        default: begin
          r_state  <= S_BOOT;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc          = r_pc;
  assign bus.if_instr    = r_if_instr;
  assign bus.if_pc       = r_if_pc;
  assign bus.if_valid    = r_if_valid;
  assign bus.halted      = r_halted;
  assign bus.fetch_count = r_fetch_count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed plus randomized bench for instr_fetch_unit; the reference model keeps
// the IF/ID contents as a queue of fetched addresses and a coarse mode value.
module tb_instr_fetch_unit;
  localparam int PC_W  = 14;
  localparam int CNT_W = 32;
  localparam int MODE_BOOT = 0, MODE_RUN = 1, MODE_HALT = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  logic [31:0] mem [0:16383];
  assign bus.ir = mem[bus.pc];

  instr_fetch_unit #(.PC_W(PC_W), .CNT_W(CNT_W), .RESET_PC(14'd0)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [PC_W-1:0]  m_pc;
  logic [PC_W-1:0]  m_q[$];
  logic [CNT_W-1:0] m_count;
  int               m_mode;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc    = '0;
    m_q     = {};
    m_count = '0;
    m_mode  = MODE_BOOT;
  endtask

  task automatic model_edge(input logic rdy, input logic rd, input logic [PC_W-1:0] rpc,
                            input logic hr);
    bit xfer;
    xfer = (m_q.size() != 0) && rdy;
    if (xfer) begin
      m_count = m_count + 1;
      void'(m_q.pop_front());
    end
    if (m_mode == MODE_BOOT) begin
      m_mode = hr ? MODE_HALT : MODE_RUN;
    end else if (rd) begin
      m_q  = {};
      m_pc = rpc;
    end else if (m_mode == MODE_RUN) begin
      if (hr) m_mode = MODE_HALT;
      else if (m_q.size() == 0) begin
        m_q.push_back(m_pc);
        m_pc = m_pc + 1;
      end
    end else if (!hr) begin
      m_mode = MODE_RUN;
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".pc"}, 64'(bus.pc), 64'(m_pc));
    chk({ctx, ".valid"}, 64'(bus.if_valid), 64'(m_q.size() != 0));
    chk({ctx, ".halted"}, 64'(bus.halted), 64'(m_mode == MODE_HALT));
    chk({ctx, ".count"}, 64'(bus.fetch_count), 64'(m_count));
    if (m_q.size() != 0) begin
      chk({ctx, ".if_pc"}, 64'(bus.if_pc), 64'(m_q[0]));
      chk({ctx, ".if_instr"}, 64'(bus.if_instr), 64'(mem[m_q[0]]));
    end
  endtask

  // Called at a falling edge; applies inputs across one rising edge and checks.
  task automatic cyc(input logic rdy, input logic rd, input logic [PC_W-1:0] rpc,
                     input logic hr);
    bus.id_ready    = rdy;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    bus.halt_req    = hr;
    model_edge(rdy, rd, rpc, hr);
    @(posedge clk);
    #1;
    $display("cyc t=%0t rdy=%0b rd=%0b rpc=%0d hr=%0b -> pc=%0d v=%0b if_pc=%0d halted=%0b cnt=%0d",
             $time, rdy, rd, rpc, hr, bus.pc, bus.if_valid, bus.if_pc, bus.halted,
             bus.fetch_count);
    check_all("step");
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string ctx);
    chk({ctx, ".pc"}, 64'(bus.pc), 64'd0);
    chk({ctx, ".if_instr"}, 64'(bus.if_instr), 64'd0);
    chk({ctx, ".if_pc"}, 64'(bus.if_pc), 64'd0);
    chk({ctx, ".valid"}, 64'(bus.if_valid), 64'd0);
    chk({ctx, ".halted"}, 64'(bus.halted), 64'd0);
    chk({ctx, ".count"}, 64'(bus.fetch_count), 64'd0);
  endtask

  // Called at a falling edge; asserts reset with no clock edge, releases at a falling edge.
  task automatic do_reset();
    bus.id_ready = 1'b1;
    bus.redirect = 1'b0;
    bus.halt_req = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("rst_async");
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("rst_hold");
    rst_n = 1'b1;
    $display("reset released t=%0t", $time);
  endtask

  task automatic run_until_ifpc(input logic [PC_W-1:0] a);
    for (int i = 0; i < 200 && !(m_q.size() != 0 && m_q[0] == a); i++)
      cyc(1'b1, 1'b0, '0, 1'b0);
    chk("reach_if_pc", 64'(bus.if_pc), 64'(a));
  endtask

  initial begin
    logic [CNT_W-1:0] cnt_save;
    logic [PC_W-1:0]  pc_save;
    logic             hr_r;

    for (int k = 0; k < 16384; k++) mem[k] = 32'h1000_0000 + k;
    bus.id_ready = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0; bus.halt_req = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset and boot
    do_reset();
    cyc(1'b1, 1'b0, '0, 1'b0);
    chk("boot_valid", 64'(bus.if_valid), 64'd0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b0, '0, 1'b0);
      chk("boot_if_pc", 64'(bus.if_pc), 64'(k));
      chk("boot_if_instr", 64'(bus.if_instr), 64'(32'h1000_0000 + k));
    end
    cyc(1'b1, 1'b0, '0, 1'b0);
    chk("boot_count3", 64'(bus.fetch_count), 64'd3);

    // Back-pressure
    run_until_ifpc(14'd5);
    cnt_save = m_count;
    repeat (4) cyc(1'b0, 1'b0, '0, 1'b0);
    chk("bp_pc", 64'(bus.pc), 64'd6);
    chk("bp_if_pc", 64'(bus.if_pc), 64'd5);
    chk("bp_count", 64'(bus.fetch_count), 64'(cnt_save));
    cyc(1'b1, 1'b0, '0, 1'b0);
    chk("bp_release", 64'(bus.if_pc), 64'd6);

    // Redirect flushes an unaccepted word
    run_until_ifpc(14'd28);
    cnt_save = m_count;
    cyc(1'b0, 1'b1, 14'd27, 1'b0);
    chk("flush_valid", 64'(bus.if_valid), 64'd0);
    chk("flush_pc", 64'(bus.pc), 64'd27);
    cyc(1'b0, 1'b0, '0, 1'b0);
    chk("flush_if_pc", 64'(bus.if_pc), 64'd27);
    chk("flush_count", 64'(bus.fetch_count), 64'(cnt_save));

    // PC wrap-around
    cyc(1'b1, 1'b1, 14'd16382, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b0);
    chk("wrap0", 64'(bus.if_pc), 64'd16382);
    cyc(1'b1, 1'b0, '0, 1'b0);
    chk("wrap1", 64'(bus.if_pc), 64'd16383);
    cyc(1'b1, 1'b0, '0, 1'b0);
    chk("wrap2", 64'(bus.if_pc), 64'd0);
    cyc(1'b1, 1'b0, '0, 1'b0);
    chk("wrap3", 64'(bus.if_pc), 64'd1);

    // Halt with a pending word, redirect while halted, resume
    cyc(1'b0, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b1);
    chk("halt_pending_valid", 64'(bus.if_valid), 64'd1);
    chk("halt_flag", 64'(bus.halted), 64'd1);
    cyc(1'b0, 1'b0, '0, 1'b1);
    cyc(1'b1, 1'b0, '0, 1'b1);
    chk("halt_drained", 64'(bus.if_valid), 64'd0);
    pc_save = m_pc;
    repeat (2) cyc(1'b1, 1'b0, '0, 1'b1);
    chk("halt_pc_const", 64'(bus.pc), 64'(pc_save));
    cyc(1'b1, 1'b1, 14'd100, 1'b1);
    chk("halt_redir_pc", 64'(bus.pc), 64'd100);
    chk("halt_redir_halted", 64'(bus.halted), 64'd1);
    cyc(1'b1, 1'b0, '0, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b0);
    chk("resume_if_pc", 64'(bus.if_pc), 64'd100);

    // Redirect and halt_req together while a transfer happens
    cnt_save = m_count;
    cyc(1'b1, 1'b1, 14'd500, 1'b1);
    chk("sim_count", 64'(bus.fetch_count), 64'(cnt_save + 1));
    chk("sim_pc", 64'(bus.pc), 64'd500);
    cyc(1'b1, 1'b0, '0, 1'b1);
    chk("sim_halted", 64'(bus.halted), 64'd1);
    chk("sim_pc_hold", 64'(bus.pc), 64'd500);
    cyc(1'b1, 1'b0, '0, 1'b0);

    // Randomized traffic with a mid-run reset; redirect during BOOT is ignored
    hr_r = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic [PC_W-1:0] rpc;
      if (i == 200) begin
        do_reset();
        cyc(1'b1, 1'b1, 14'd77, 1'b0);
        chk("boot_redirect_ignored", 64'(bus.pc), 64'd0);
      end
      if ($urandom_range(0, 14) == 0) hr_r = ~hr_r;
      rpc = ($urandom_range(0, 3) == 0) ? 14'(16380 + $urandom_range(0, 3)) : 14'($urandom);
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, rpc, hr_r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage that drives the 14-bit word-address PC into the combinational instruction memory and captures the returned 32-bit IR into the IF/ID pipeline register.
- Presents fetched instructions to decode through a valid/ready handshake.
- Accepts PC redirects (jumps/branches resolved downstream) and halt requests.
- Keeps a fetch counter for software/bench visibility.

Parameters:
- RESET_PC, 14'd0, PC value loaded on reset.
- PC_W, 14, instruction word-address width; must equal the memory's PC width.
- CNT_W, 32, width of the fetch counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pc  out  PC_W  word address to instruction memory.
- ir  in  32  instruction word from memory (combinational read of pc).
- if_instr  out  32  IF/ID instruction register.
- if_pc  out  PC_W  address of if_instr.
- if_valid  out  1  IF/ID holds a valid instruction.
- id_ready  in  1  decode accepts if_instr this cycle.
- redirect  in  1  taken jump/branch; one-cycle pulse.
- redirect_pc  in  PC_W  target address accompanying redirect.
- halt_req  in  1  level; stop fetching while high.
- halted  out  1  fetch unit is in HALT.
- fetch_count  out  CNT_W  number of instructions handed to decode.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - pc=RESET_PC, if_instr=32'd0, if_pc=0, if_valid=0, halted=0, fetch_count=0, state=BOOT.
  - Reset mid-operation discards IF/ID contents immediately.
- State machine:
  - BOOT: exactly one cycle after reset release, no fetch, pc held at RESET_PC; then -> RUN, or -> HALT if halt_req=1.
  - RUN: normal fetching; -> HALT when halt_req=1 and no redirect is present this cycle.
  - HALT: pc held, halted=1, if_valid=0 once any pending instruction is accepted; -> RUN when halt_req=0.
- Transfer: occurs on a clock edge where if_valid=1 and id_ready=1. fetch_count increments by 1 per transfer and wraps modulo 2^CNT_W.
- Fetch (RUN, no redirect): when IF/ID is empty or transferring this cycle:
  - if_instr<=ir, if_pc<=pc, if_valid<=1, pc<=pc+1.
  - Otherwise, stall: pc, if_instr, if_pc and if_valid all hold.
  - Latency: the instruction at address A appears on if_instr one cycle after pc=A.
- PC arithmetic: unsigned, width PC_W. 16383+1 wraps to 0. No overflow flag.
- Redirect (any state except BOOT; highest priority):
  - pc<=redirect_pc and if_valid<=0, flushing the IF/ID contents even if unaccepted.
  - fetch_count still counts a transfer occurring on that same edge.
  - Redirect in HALT updates pc but remains in HALT.
- Simultaneous redirect and stall: redirect wins.
- Simultaneous redirect and halt_req: apply the redirect, enter HALT next cycle if halt_req is still 1.
- Halt entry: no new fetch. An unaccepted valid instruction stays valid until transferred; pc holds the next sequential address.
- Handshake rule: if_instr and if_pc must stay stable while if_valid=1 and id_ready=0.
- No hazard detection; NOP padding by software is relied upon.
- Opcodes are not decoded: fetch is opcode-agnostic, and a NOP word is fetched and counted like any other.
- In BOOT, redirect is ignored.

Test Plan:
- Reset/boot: assert rst_n=0 mid-run, release with id_ready=1 and memory word k = 32'h1000_0000+k -> all outputs zero during reset; if_valid=0 for the BOOT cycle; then if_pc=0,1,2 with if_instr=32'h1000_0000,..01,..02 on consecutive cycles; fetch_count=3 after three transfers.
- Back-pressure: hold id_ready=0 for 4 cycles while if_pc=5 -> if_instr/if_pc frozen, pc stays 6, fetch_count unchanged; release -> if_pc=6 next cycle.
- Redirect/flush: at if_pc=28, pulse redirect with redirect_pc=27 and id_ready=0 -> next cycle if_valid=0, pc=27; following cycle if_pc=27 valid; the flushed word is never counted.
- Wrap-around: redirect to 16382 -> if_pc sequence 16382, 16383, 0, 1.
- Halt: raise halt_req while if_valid=1 and id_ready=0 -> pending word held until id_ready=1; then halted=1, if_valid=0, pc constant. Redirect to 100 during HALT -> pc=100, still halted. Drop halt_req -> first fetched if_pc=100.
- Simultaneous redirect and halt_req with id_ready=1 -> the transfer is counted, pc=redirect_pc, halted=1 the following cycle.
